// File: rtl/restador_64_bits_secuencial_if.sv
// Operand/result handshake bundle for the sequential subtractor.
// master = producer/consumer side, slave = the subtractor itself.
interface restador_64_bits_secuencial_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/restador_64_bits_secuencial.sv
// Multi-cycle subtractor: diff = a - b - bin, one CHUNK-bit slice per cycle.
// Optional macro RESTADOR_SAT_EN clamps diff to the signed limit on overflow.
module restador_64_bits_secuencial #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input logic                           clk,
    input logic                           rst_n,
    restador_64_bits_secuencial_if.slave  bus
);
    localparam int NUM_SLICES = WIDTH / CHUNK;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_next;
    logic             started;
    logic [IDX_W-1:0] idx;
    logic             borrow;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic             bout_q, ovf_q;

    logic             accept, last_slice;
    logic [CHUNK-1:0] a_slice, b_slice, d;
    logic             borrow_next, ovf_raw;

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) started <= 1'b0;
        else        started <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_next = state;
        accept     = 1'b0;
        unique case (state)
            IDLE: if (bus.in_valid && started) begin
                accept     = 1'b1;
                state_next = CALC;
            end
            CALC: if (last_slice) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One narrow subtract stage, shared by every slice.
    always_comb begin
        a_slice              = a_q[int'(idx)*CHUNK +: CHUNK];
        b_slice              = b_q[int'(idx)*CHUNK +: CHUNK];
        {borrow_next, d}     = {1'b0, a_slice} - {1'b0, b_slice} - {{CHUNK{1'b0}}, borrow};
        last_slice           = (idx == LAST_IDX);
        ovf_raw              = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d[CHUNK-1] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            borrow <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            a_q    <= bus.a;
            b_q    <= bus.b;
            borrow <= bus.bin;
            idx    <= '0;
        end else if (state == CALC) begin
            diff_q[int'(idx)*CHUNK +: CHUNK] <= d;
            borrow <= borrow_next;
            idx    <= idx + 1'b1;
            if (last_slice) begin
                bout_q <= borrow_next;
                ovf_q  <= ovf_raw;
`ifdef RESTADOR_SAT_EN
                // A non-negative minuend can only overflow upward.
                if (ovf_raw)
                    diff_q <= a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
`endif
            end
        end
    end

    assign bus.in_ready  = (state == IDLE) && started;
    assign bus.out_valid = (state == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_restador_64_bits_secuencial.sv
// Directed bench for restador_64_bits_secuencial: vector table plus hold and
// mid-operation reset sequences. Define RESTADOR_SAT_EN to check the clamped build.
module tb_restador_64_bits_secuencial;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    restador_64_bits_secuencial_if #(.WIDTH(64)) bus ();

    restador_64_bits_secuencial #(.WIDTH(64), .CHUNK(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] exp_diff;
        logic        exp_bout;
        logic        exp_ovf;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, wanted 0x%h", name, act, exp);
        end
    endtask

    // Called on a negedge; returns on a negedge with the result either
    // released (do_release=1) or still presented in DONE.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bin,
                          input logic [63:0] exp_diff, input logic exp_bout, input logic exp_ovf,
                          input string tag, input bit do_release);
        int waitc = 0;
        int lat   = 0;
        while (!bus.in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " diff"}, bus.diff, exp_diff);
        check({tag, " bout"}, 64'(bus.bout), 64'(exp_bout));
        check({tag, " ovf"},  64'(bus.ovf),  64'(exp_ovf));
        if (do_release) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, wanted completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] sat_neg, sat_pos;
`ifdef RESTADOR_SAT_EN
        sat_neg = 64'h8000_0000_0000_0000;
        sat_pos = 64'h7FFF_FFFF_FFFF_FFFF;
`else
        sat_neg = 64'h7FFF_FFFF_FFFF_FFFF;
        sat_pos = 64'h8000_0000_0000_0000;
`endif
        vecs[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, "5-3"};
        vecs[1] = '{64'd5, 64'd3, 1'b1, 64'd1, 1'b0, 1'b0, "5-3-1"};
        vecs[2] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "0-1"};
        vecs[3] = '{64'h0000_0000_0001_0000, 64'd1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, "slice01"};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, sat_neg, 1'b0, 1'b1, "neg_ovf"};
        vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, sat_pos, 1'b1, 1'b1, "pos_ovf"};
        vecs[6] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "0-0-1"};
        vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                    64'h0246_8ACF_1357_9BCF, 1'b0, 1'b0, "mixed"};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst in_ready",  64'(bus.in_ready),  64'd0);
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst diff",      bus.diff,           64'd0);
        check("rst bout",      64'(bus.bout),      64'd0);
        check("rst ovf",       64'(bus.ovf),       64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst in_ready", 64'(bus.in_ready), 64'd1);

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff,
                   vecs[i].exp_bout, vecs[i].exp_ovf, vecs[i].name, 1'b1);

        // Result held in DONE while the producer keeps pushing new operands.
        run_op(64'd9, 64'd4, 1'b0, 64'd5, 1'b0, 1'b0, "hold", 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 64'hDEAD_0000 + 64'(i);
            bus.b        = 64'hFFFF_0000_0000_0000;
            bus.bin      = 1'(i);
            @(negedge clk);
            check("hold diff",      bus.diff,           64'd5);
            check("hold bout",      64'(bus.bout),      64'd0);
            check("hold ovf",       64'(bus.ovf),       64'd0);
            check("hold in_ready",  64'(bus.in_ready),  64'd0);
            check("hold out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("release in_ready",  64'(bus.in_ready),  64'd1);
        check("release out_valid", 64'(bus.out_valid), 64'd0);
        check("idle keeps diff",   bus.diff,           64'd5);
        run_op(64'd100, 64'd1, 1'b0, 64'd99, 1'b0, 1'b0, "after_hold", 1'b1);

        // Abort after two CALC cycles with an asynchronous reset.
        bus.a        = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.b        = 64'h0000_0000_0000_0001;
        bus.bin      = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort in_ready",  64'(bus.in_ready),  64'd0);
        check("abort out_valid", 64'(bus.out_valid), 64'd0);
        check("abort diff",      bus.diff,           64'd0);
        check("abort bout",      64'(bus.bout),      64'd0);
        check("abort ovf",       64'(bus.ovf),       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("release edge in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("after abort in_ready", 64'(bus.in_ready), 64'd1);
        run_op(64'd7, 64'd2, 1'b0, 64'd5, 1'b0, 1'b0, "7-2", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/restador_64_bits_secuencial.md
Name: restador_64_bits_secuencial

Overview:
Multi-cycle 64-bit subtractor; the inverse operation of the team's ripple adder chain. Computes diff = a - b - bin one CHUNK-bit slice per cycle, propagating a borrow between slices, so a single narrow subtract stage serves the whole word. It sits beside the adder datapath and exchanges operands and results over valid/ready handshakes. It reports borrow-out and signed overflow.

Parameters:
WIDTH, 64, operand/result width; must be an integer multiple of CHUNK
CHUNK, 16, bits subtracted per cycle; NUM_SLICES = WIDTH/CHUNK (4 by default)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, bin valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  borrow out; 1 when unsigned a < b + bin
ovf  output  1  signed two's-complement overflow

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, slice index=0, internal borrow=0, diff=0, bout=0, ovf=0, out_valid=0, in_ready=0. The cycle after deassertion, in_ready=1.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1, out_valid=0.
  - On an edge with in_valid=1, a, b and bin are latched, the borrow register is set to bin, the index is set to 0, and the FSM moves to CALC.
- CALC: in_ready=0, out_valid=0.
  - Each edge computes {borrow_next, d} = a_slice[idx] - b_slice[idx] - borrow at CHUNK+1 bits.
  - d is written to diff[idx*CHUNK +: CHUNK], borrow takes borrow_next, and idx increments.
  - After slice NUM_SLICES-1: bout = final borrow, ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]). The FSM moves to DONE.
- DONE: out_valid=1, in_ready=0. diff, bout and ovf are held stable.
  - On an edge with out_ready=1, the FSM returns to IDLE.
  - out_ready=0 keeps the FSM in DONE indefinitely; there is no timeout.
- Latency: out_valid rises exactly NUM_SLICES cycles after the accepting edge (4 by default). Throughput is at most one operation per NUM_SLICES+2 cycles.
- Outputs in IDLE: diff, bout and ovf keep the last result until the next accept. Consumers must qualify them with out_valid.
- Input changes: changes on a, b and bin while in CALC or DONE are ignored, because the operands are latched.
- Reset mid-operation: asserting rst_n low in any state aborts the operation immediately. No partial result is ever presented.
- Handshakes: in_valid is ignored outside IDLE. No combinational path exists from out_ready to in_ready.
- Wrap-around: the result is always modulo 2^WIDTH. bout indicates the unsigned wrap.

Optional Feature:
Macro RESTADOR_SAT_EN.
- Defined: when ovf=1, diff is clamped to the signed limit.
  - Positive overflow (a non-negative, b negative) gives 0x7FFF_FFFF_FFFF_FFFF.
  - Negative overflow gives 0x8000_0000_0000_0000.
  - The clamp is applied on the transition into DONE. ovf and bout still report the raw, unsaturated condition.
- Undefined: diff is the plain modulo result.
- Timing and latency are identical in both builds.

Test Plan:
1. a=5, b=3, bin=0 -> diff=2, bout=0, ovf=0, out_valid 4 cycles after accept. Repeat with bin=1 -> diff=1.
2. a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0 (borrow ripples through all 4 slices).
3. a=0x0000_0000_0001_0000, b=1 -> diff=0x0000_0000_0000_FFFF, bout=0 (borrow crosses the slice 0/1 boundary).
4. a=0x8000_0000_0000_0000, b=1 -> ovf=1, bout=0. Without the macro diff=0x7FFF_FFFF_FFFF_FFFF; with RESTADOR_SAT_EN diff=0x8000_0000_0000_0000.
5. Hold out_ready=0 for 3 cycles in DONE while toggling in_valid, a and b -> diff, bout and ovf remain stable, in_ready=0, nothing accepted. After the out_ready=1 handshake, in_ready=1 on the next cycle and a new operation is accepted.
6. Pull rst_n low after 2 CALC cycles -> all outputs 0 immediately (asynchronously). After release, in_ready=1, and a=7, b=2 then yields diff=5.
